apb_master: RTL and testbench

Single-outstanding APB requester that turns a valid/ready command into one APB transfer and returns the result on a valid/ready response channel. It drives the APB bus of the peripheral slaves, including the APB timer, from the system controller side. It also enforces a bounded wait on `pready` so a hung slave cannot stall the controller.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_counter.sv | 40 ++++
 rtl/apb_master.sv | 158 +++++++++++++++
 tb/tb_apb_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
// Reused by the requester and by the peripheral slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam int APB_DATA_W = 9;
  localparam int APB_ADDR_W = 1;

endpackage

// File: rtl/apb_wait_counter.sv
// Saturating wait-state counter for the APB requester. Counts ACCESS cycles
// with pready low and flags the cycle on which the next count reaches TIMEOUT.
module apb_wait_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looks one count ahead so the abort lands on the TIMEOUT-th waiting cycle.
  assign expired = (TIMEOUT > 0) && (count_q == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one valid/ready command becomes one APB
// transfer, answered on a valid/ready response channel with a bounded wait.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_W  = APB_DATA_W,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_expired;

  apb_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          cnt_clr  = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A completing slave wins over a timeout landing in the same cycle.
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_d       = RESP;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table of single transfers scored against a queue of
// expected responses, plus back-pressure and mid-transfer reset sequences.
module tb_apb_master;

  localparam int DATA_W  = 9;
  localparam int ADDR_W  = 1;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  apb_master #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                wait_n;
    logic [DATA_W-1:0] prd;
    logic              slverr;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    logic              exp_to;
    int                exp_lat;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              to;
    int                lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t_acc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: pready low for slave_wait ACCESS cycles, junk data while not ready.
  int                slave_wait   = 0;
  logic [DATA_W-1:0] slave_prdata = '0;
  logic              slave_err    = 1'b0;
  int                acc_cnt      = 0;

  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc_cnt >= slave_wait);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
    prdata  = pready ? slave_prdata : 9'h1EE;
    pslverr = pready ? slave_err : 1'b1;
  end

  // Response monitor: each new response pops one expectation.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid && !rv_prev) begin
      check("rsp_expected", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("rsp_latency", cyc - t_acc + 1, mon_e.lat);
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", rsp_err, mon_e.err);
        check("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
    rv_prev = rsp_valid;
  end

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic run_cmd(input vec_t v);
    exp_t e;
    @(negedge clk);
    slave_wait   = v.wait_n;
    slave_prdata = v.prd;
    slave_err    = v.slverr;
    cmd_valid    = 1'b1;
    cmd_write    = v.write;
    cmd_addr     = v.addr;
    cmd_wdata    = v.wdata;
    check("idle_cmd_ready", cmd_ready, 1);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.to    = v.exp_to;
    e.lat   = v.exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    t_acc     = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_pwrite", pwrite, v.write);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwdata", pwdata, v.wdata);
    @(negedge clk);
    check("access_psel", psel, 1);
    check("access_penable", penable, 1);
    check("access_pwdata", pwdata, v.wdata);
    wait_done("rsp_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  vec_t vecs[8];
  vec_t v_after;
  int   seen;

  initial begin
    //          wr    addr  wdata    wait  prdata   serr  exp_rd   err   to    lat
    vecs[0] = '{1'b1, 1'b0, 9'd20,   0,    9'h000,  1'b0, 9'h000,  1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 1'b0, 9'd0,    3,    9'd7,    1'b0, 9'd7,    1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 1'b1, 9'h055,  0,    9'h1A5,  1'b1, 9'h1A5,  1'b1, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 9'h1FF,  2,    9'h0C3,  1'b1, 9'h000,  1'b1, 1'b0, 5};
    vecs[4] = '{1'b0, 1'b0, 9'h000,  1000, 9'h0AA,  1'b0, 9'h000,  1'b1, 1'b1, 17};
    vecs[5] = '{1'b0, 1'b1, 9'h000,  14,   9'h0AA,  1'b0, 9'h0AA,  1'b0, 1'b0, 17};
    vecs[6] = '{1'b0, 1'b0, 9'h000,  13,   9'h155,  1'b0, 9'h155,  1'b0, 1'b0, 16};
    vecs[7] = '{1'b1, 1'b0, 9'h0F5,  1000, 9'h001,  1'b0, 9'h000,  1'b1, 1'b1, 17};

    repeat (3) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    reset = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Response back-pressure with the next command already waiting.
    @(negedge clk);
    slave_wait   = 0;
    slave_prdata = 9'h033;
    slave_err    = 1'b0;
    rsp_ready    = 1'b0;
    cmd_valid    = 1'b1;
    cmd_write    = 1'b0;
    cmd_addr     = 1'b0;
    cmd_wdata    = 9'h000;
    sb_q.push_back('{9'h033, 1'b0, 1'b0, 3});
    @(posedge clk);
    #1;
    t_acc     = cyc;
    cmd_write = 1'b1;
    cmd_addr  = 1'b1;
    cmd_wdata = 9'h0F0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 9'h033);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", psel, 0);
    end
    @(negedge clk);
    check("bp_rsp_valid_last", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{9'h000, 1'b0, 1'b0, 3});
    @(negedge clk);
    check("bp_idle_cmd_ready", cmd_ready, 1);
    check("bp_idle_rsp_valid", rsp_valid, 0);
    check("bp_idle_psel", psel, 0);
    @(posedge clk);
    #1;
    t_acc     = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_next_psel", psel, 1);
    check("bp_next_penable", penable, 0);
    check("bp_next_pwrite", pwrite, 1);
    check("bp_next_paddr", paddr, 1);
    check("bp_next_pwdata", pwdata, 9'h0F0);
    wait_done("bp_done");

    // Reset asserted while the slave is stalling in ACCESS.
    @(negedge clk);
    slave_wait = 1000;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 1'b1;
    cmd_wdata  = 9'h1C3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_pre_psel", psel, 1);
    check("mid_pre_penable", penable, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_psel", psel, 0);
    check("mid_penable", penable, 0);
    check("mid_pwrite", pwrite, 0);
    check("mid_paddr", paddr, 0);
    check("mid_pwdata", pwdata, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    slave_wait = 0;
    seen       = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", seen, 0);

    v_after = '{1'b1, 1'b1, 9'h123, 1, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 4};
    run_cmd(v_after);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
